// File: rtl/neighbor_table_writer.sv
// Producer side of the shared neighbor table: per start pulse, look up the reported
// neighbor ID, then update its entry in place or append it and bump neighborCount.
module neighbor_table_writer #(
    parameter int MAX_NEIGHBORS = 64
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] pkt_neighborID,
    input  logic [15:0] pkt_clusterID,
    input  logic [15:0] pkt_batteryStat,
    input  logic [15:0] pkt_qValue,
    input  logic [15:0] data_in,
    output logic [10:0] address,
    output logic        wr_en,
    output logic [15:0] data_out,
    output logic        done,
    output logic [15:0] entry_index,
    output logic        new_entry,
    output logic        table_full
);

    // state   | meaning
    // IDLE    | waiting for start; count read is issued on the accepting edge
    // RD_CNT  | neighborCount on data_in; clamp it, begin scan or go straight to append
    // SCAN    | ID at r_idx on data_in; compare against the latched report ID
    // WR_ID   | neighborID write on the bus (append only)
    // WR_CLUS | clusterID write on the bus
    // WR_BAT  | batteryStat write on the bus
    // WR_Q    | qValue write on the bus
    // WR_CNT  | neighborCount = n+1 write on the bus (append only)
    // DONE    | done pulse; results held on entry_index/new_entry/table_full
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_CNT  = 4'd1;
    localparam logic [3:0] S_SCAN    = 4'd2;
    localparam logic [3:0] S_WR_ID   = 4'd3;
    localparam logic [3:0] S_WR_CLUS = 4'd4;
    localparam logic [3:0] S_WR_BAT  = 4'd5;
    localparam logic [3:0] S_WR_Q    = 4'd6;
    localparam logic [3:0] S_WR_CNT  = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [10:0] ID_BASE   = 11'h048;
    localparam logic [10:0] CLUS_BASE = 11'h0C8;
    localparam logic [10:0] BAT_BASE  = 11'h148;
    localparam logic [10:0] Q_BASE    = 11'h1C8;
    localparam logic [10:0] CNT_ADDR  = 11'h68A;
    localparam logic [15:0] MAX_N     = 16'(MAX_NEIGHBORS);

    logic [3:0]  r_state;
    logic [15:0] r_id;
    logic [15:0] r_clus;
    logic [15:0] r_bat;
    logic [15:0] r_q;
    logic [15:0] r_count;
    logic [15:0] r_idx;
    logic        r_new;

    logic [15:0] w_count_in;
    logic [15:0] w_next_idx;
    logic        w_id_match;

    assign w_count_in = (data_in > MAX_N) ? MAX_N : data_in;
    assign w_next_idx = r_idx + 16'd1;
    assign w_id_match = (data_in == r_id);

    function automatic logic [10:0] f_word_addr(input logic [10:0] base, input logic [9:0] idx);
        return base + {idx, 1'b0};
    endfunction

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_clus      <= '0;
            r_bat       <= '0;
            r_q         <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_new       <= 1'b0;
            address     <= '0;
            wr_en       <= 1'b0;
            data_out    <= '0;
            done        <= 1'b0;
            entry_index <= '0;
            new_entry   <= 1'b0;
            table_full  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_id        <= pkt_neighborID;
                        r_clus      <= pkt_clusterID;
                        r_bat       <= pkt_batteryStat;
                        r_q         <= pkt_qValue;
                        address     <= CNT_ADDR;
                        entry_index <= '0;
                        new_entry   <= 1'b0;
                        table_full  <= 1'b0;
                        r_state     <= S_RD_CNT;
                    end
                end
                S_RD_CNT: begin
                    r_count <= w_count_in;
                    r_idx   <= '0;
                    if (w_count_in == 16'd0) begin
                        r_new    <= 1'b1;
                        wr_en    <= 1'b1;
                        address  <= ID_BASE;
                        data_out <= r_id;
                        r_state  <= S_WR_ID;
                    end else begin
                        address <= ID_BASE;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_id_match) begin
                        r_new    <= 1'b0;
                        wr_en    <= 1'b1;
                        address  <= f_word_addr(CLUS_BASE, r_idx[9:0]);
                        data_out <= r_clus;
                        r_state  <= S_WR_CLUS;
                    end else if (w_next_idx < r_count) begin
                        r_idx   <= w_next_idx;
                        address <= f_word_addr(ID_BASE, w_next_idx[9:0]);
                    end else if (r_count < MAX_N) begin
                        r_idx    <= r_count;
                        r_new    <= 1'b1;
                        wr_en    <= 1'b1;
                        address  <= f_word_addr(ID_BASE, r_count[9:0]);
                        data_out <= r_id;
                        r_state  <= S_WR_ID;
                    end else begin
                        // scanned a full table without a hit: drop the report
                        table_full <= 1'b1;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_WR_ID: begin
                    wr_en    <= 1'b1;
                    address  <= f_word_addr(CLUS_BASE, r_idx[9:0]);
                    data_out <= r_clus;
                    r_state  <= S_WR_CLUS;
                end
                S_WR_CLUS: begin
                    wr_en    <= 1'b1;
                    address  <= f_word_addr(BAT_BASE, r_idx[9:0]);
                    data_out <= r_bat;
                    r_state  <= S_WR_BAT;
                end
                S_WR_BAT: begin
                    wr_en    <= 1'b1;
                    address  <= f_word_addr(Q_BASE, r_idx[9:0]);
                    data_out <= r_q;
                    r_state  <= S_WR_Q;
                end
                S_WR_Q: begin
                    // count goes last so a reset mid-append never counts a partial entry
                    if (r_new) begin
                        wr_en    <= 1'b1;
                        address  <= CNT_ADDR;
                        data_out <= r_count + 16'd1;
                        r_state  <= S_WR_CNT;
                    end else begin
                        done        <= 1'b1;
                        entry_index <= r_idx;
                        new_entry   <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_WR_CNT: begin
                    done        <= 1'b1;
                    entry_index <= r_idx;
                    new_entry   <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
